// File: rtl/ifetch_queue_if.sv
// Fetch-unit bundle: xbus read request/response toward instruction memory
// plus the valid/ready instruction stream toward decode.
interface ifetch_queue_if;
    logic        xbus_cs;
    logic        xbus_we;
    logic [3:0]  xbus_be;
    logic [31:0] xbus_addr;
    logic [31:0] xbus_wdata;
    logic [31:0] xbus_rdata;
    logic        xbus_ready;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output xbus_cs, xbus_we, xbus_be, xbus_addr, xbus_wdata,
        input  xbus_rdata, xbus_ready,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  xbus_cs, xbus_we, xbus_be, xbus_addr, xbus_wdata,
        output xbus_rdata, xbus_ready,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential xbus word fetches into a small
// FIFO drained by decode; redirects flush the queue and restart fetch.
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    ifetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [63:0]        mem_q [DEPTH];
    logic               push;
    logic               pop;

    // Redirect gates the request combinationally so nothing is pushed during a flush.
    assign bus.xbus_cs    = (state_q == FETCH) && !redirect_valid;
    assign bus.xbus_we    = 1'b0;
    assign bus.xbus_be    = 4'hF;
    assign bus.xbus_addr  = fetch_pc_q;
    assign bus.xbus_wdata = 32'h0;

    assign push = bus.xbus_cs && bus.xbus_ready;
    assign pop  = bus.inst_valid && bus.inst_ready && !redirect_valid;

    assign bus.inst_valid = (count_q != '0);
    assign {bus.inst_pc, bus.inst_data} = bus.inst_valid ? mem_q[rd_ptr_q] : 64'h0;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            state_d    = fetch_en ? FETCH : IDLE;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            // Every state shares one exit rule: park when disabled, hold when full.
            case (state_q)
                IDLE, FETCH, HOLD: begin
                    if (!fetch_en)           state_d = IDLE;
                    else if (count_d == FULL) state_d = HOLD;
                    else                     state_d = FETCH;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {fetch_pc_q, bus.xbus_rdata};
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus random traffic checked
// against a queue-based model of the fetch stream.
module tb_ifetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        xbus_ready = 1'b1;
    logic        inst_ready = 1'b1;

    int total  = 0;
    int passes = 0;

    // Model: queue of pushed PCs, next fetch PC, and whether a request is due.
    logic [31:0] m_q[$];
    logic [31:0] m_pc;
    bit          m_active;

    ifetch_queue_if bus();

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0093;
        if (a == 32'h4) return 32'h0000_0113;
        return {~a[31:16], a[15:0]} ^ 32'h0000_0013;
    endfunction

    assign bus.xbus_rdata = rom(bus.xbus_addr);
    assign bus.xbus_ready = xbus_ready;
    assign bus.inst_ready = inst_ready;

    ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_pc     = RESET_PC;
        m_active = 1'b0;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_clock();
        bit push, pop;
        if (redirect_valid) begin
            m_q.delete();
            m_pc     = {redirect_pc[31:2], 2'b00};
            m_active = fetch_en;
            return;
        end
        push = m_active && xbus_ready;
        pop  = (m_q.size() != 0) && inst_ready;
        if (pop)  void'(m_q.pop_front());
        if (push) begin m_q.push_back(m_pc); m_pc = m_pc + 32'd4; end
        m_active = fetch_en && (m_q.size() < DEPTH);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
        #2;
        total++; if (bus.xbus_cs !== 1'b0) $display("FAIL reset_cs got=%b exp=0", bus.xbus_cs); else passes++;
        total++; if (bus.inst_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.inst_valid); else passes++;
        total++; if (bus.inst_data !== 32'h0) $display("FAIL reset_data got=%h exp=0", bus.inst_data); else passes++;
        total++; if (bus.inst_pc !== 32'h0) $display("FAIL reset_pc got=%h exp=0", bus.inst_pc); else passes++;
        total++; if (bus.xbus_we !== 1'b0) $display("FAIL reset_we got=%b exp=0", bus.xbus_we); else passes++;
        total++; if (bus.xbus_be !== 4'hF) $display("FAIL reset_be got=%h exp=f", bus.xbus_be); else passes++;
        total++; if (bus.xbus_wdata !== 32'h0) $display("FAIL reset_wdata got=%h exp=0", bus.xbus_wdata); else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_boot();
        fetch_en = 1'b1; xbus_ready = 1'b1; inst_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++; if (bus.xbus_cs !== (m_active && !redirect_valid))
                $display("FAIL boot_cs cyc=%0d got=%b exp=%b", i, bus.xbus_cs, m_active); else passes++;
            total++; if (bus.xbus_we !== 1'b0 || bus.xbus_be !== 4'hF)
                $display("FAIL boot_we_be cyc=%0d got=%b/%h exp=0/f", i, bus.xbus_we, bus.xbus_be); else passes++;
            if (i == 2) begin
                total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst_data !== 32'h93)
                    $display("FAIL boot_first got=%b/%h/%h exp=1/0/00000093", bus.inst_valid, bus.inst_pc, bus.inst_data); else passes++;
            end
            if (i == 3) begin
                total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h4 || bus.inst_data !== 32'h113)
                    $display("FAIL boot_second got=%b/%h/%h exp=1/4/00000113", bus.inst_valid, bus.inst_pc, bus.inst_data); else passes++;
            end
            if (i >= 2) begin
                total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * (i - 2)))
                    $display("FAIL boot_stream cyc=%0d got=%b/%h exp=1/%h", i, bus.inst_valid, bus.inst_pc, 32'(4 * (i - 2))); else passes++;
            end
            model_clock();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int pushes = 0;
        logic [31:0] nxt = 32'h0;
        do_reset();
        fetch_en = 1'b1; inst_ready = 1'b0; xbus_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.xbus_cs && xbus_ready) begin
                total++; if (bus.xbus_addr !== 32'(4 * pushes))
                    $display("FAIL bp_addr got=%h exp=%h", bus.xbus_addr, 32'(4 * pushes)); else passes++;
                pushes++;
            end
            model_clock();
            @(posedge clk); #1;
        end
        total++; if (pushes != DEPTH) $display("FAIL bp_push_count got=%0d exp=%0d", pushes, DEPTH); else passes++;
        total++; if (bus.xbus_cs !== 1'b0 || bus.inst_valid !== 1'b1)
            $display("FAIL bp_hold got cs=%b valid=%b exp cs=0 valid=1", bus.xbus_cs, bus.inst_valid); else passes++;
        inst_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.inst_valid) begin
                total++; if (bus.inst_pc !== nxt || bus.inst_data !== rom(nxt))
                    $display("FAIL bp_pop got=%h/%h exp=%h/%h", bus.inst_pc, bus.inst_data, nxt, rom(nxt)); else passes++;
                nxt = nxt + 32'd4;
            end
            model_clock();
            @(posedge clk); #1;
        end
        total++; if (nxt !== 32'h28) $display("FAIL bp_resume got=%h exp=00000028", nxt); else passes++;
    endtask

    task automatic test_redirect();
        do_reset();
        fetch_en = 1'b1; inst_ready = 1'b1; xbus_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            model_clock();
            @(posedge clk); #1;
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0083;
        @(negedge clk);
        total++; if (bus.xbus_cs !== 1'b0) $display("FAIL redir_cs got=%b exp=0", bus.xbus_cs); else passes++;
        model_clock();
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        total++; if (bus.inst_valid !== 1'b0) $display("FAIL redir_flush got=%b exp=0", bus.inst_valid); else passes++;
        total++; if (bus.xbus_cs !== 1'b1 || bus.xbus_addr !== 32'h80)
            $display("FAIL redir_addr got=%b/%h exp=1/00000080", bus.xbus_cs, bus.xbus_addr); else passes++;
        model_clock();
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h80 || bus.inst_data !== rom(32'h80))
            $display("FAIL redir_first got=%b/%h/%h exp=1/00000080/%h", bus.inst_valid, bus.inst_pc, bus.inst_data, rom(32'h80)); else passes++;
        model_clock();
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        int stalls = 0;
        int pops8 = 0;
        do_reset();
        fetch_en = 1'b1; inst_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            xbus_ready = !(m_active && m_pc == 32'h8 && stalls < 3);
            @(negedge clk);
            if (bus.xbus_cs && !xbus_ready) begin
                stalls++;
                total++; if (bus.xbus_addr !== 32'h8) $display("FAIL stall_addr got=%h exp=00000008", bus.xbus_addr); else passes++;
            end
            total++; if (bus.inst_valid !== (m_q.size() != 0))
                $display("FAIL stall_valid got=%b exp=%b", bus.inst_valid, m_q.size() != 0); else passes++;
            if (bus.inst_valid && m_q.size() != 0) begin
                total++; if (bus.inst_pc !== m_q[0]) $display("FAIL stall_pc got=%h exp=%h", bus.inst_pc, m_q[0]); else passes++;
                if (bus.inst_pc === 32'h8) pops8++;
            end
            model_clock();
            @(posedge clk); #1;
        end
        xbus_ready = 1'b1;
        total++; if (stalls != 3) $display("FAIL stall_cycles got=%0d exp=3", stalls); else passes++;
        total++; if (pops8 != 1) $display("FAIL stall_once got=%0d exp=1", pops8); else passes++;
    endtask

    task automatic test_wrap();
        do_reset();
        fetch_en = 1'b1; inst_ready = 1'b1; xbus_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk); model_clock(); @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        total++; if (bus.xbus_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_top got=%h exp=fffffffc", bus.xbus_addr); else passes++;
        model_clock(); @(posedge clk); #1;
        @(negedge clk);
        total++; if (bus.xbus_addr !== 32'h0) $display("FAIL wrap_zero got=%h exp=00000000", bus.xbus_addr); else passes++;
        total++; if (bus.inst_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_head got=%h exp=fffffffc", bus.inst_pc); else passes++;
        model_clock(); @(posedge clk); #1;
        @(negedge clk);
        total++; if (bus.inst_pc !== 32'h0) $display("FAIL wrap_next got=%h exp=00000000", bus.inst_pc); else passes++;
        model_clock(); @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        bit seen = 0;
        do_reset();
        fetch_en = 1'b1; inst_ready = 1'b0; xbus_ready = 1'b1;
        for (int i = 0; i < 20 && m_q.size() != 3; i++) begin
            @(negedge clk); model_clock(); @(posedge clk); #1;
        end
        total++; if (m_q.size() != 3 || bus.inst_valid !== 1'b1 || bus.xbus_cs !== 1'b1)
            $display("FAIL arst_fill got valid=%b cs=%b exp valid=1 cs=1", bus.inst_valid, bus.xbus_cs); else passes++;
        #2 rst = 1'b1;
        #1;
        total++; if (bus.inst_valid !== 1'b0 || bus.xbus_cs !== 1'b0)
            $display("FAIL arst_immediate got valid=%b cs=%b exp 0/0", bus.inst_valid, bus.xbus_cs); else passes++;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0; inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.xbus_cs && !seen) begin
                seen = 1;
                total++; if (bus.xbus_addr !== RESET_PC) $display("FAIL arst_restart got=%h exp=%h", bus.xbus_addr, RESET_PC); else passes++;
            end
            model_clock(); @(posedge clk); #1;
        end
        total++; if (!seen) $display("FAIL arst_no_fetch got=0 exp=1"); else passes++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            fetch_en       = ($urandom_range(0, 15) != 0);
            xbus_ready     = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc    = $urandom;
            @(negedge clk);
            total++; if (bus.xbus_cs !== (m_active && !redirect_valid))
                $display("FAIL rnd_cs cyc=%0d got=%b exp=%b", i, bus.xbus_cs, m_active && !redirect_valid); else passes++;
            if (bus.xbus_cs) begin
                total++; if (bus.xbus_addr !== m_pc) $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, bus.xbus_addr, m_pc); else passes++;
            end
            total++; if (bus.inst_valid !== (m_q.size() != 0))
                $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, bus.inst_valid, m_q.size() != 0); else passes++;
            if (m_q.size() != 0) begin
                total++; if (bus.inst_pc !== m_q[0] || bus.inst_data !== rom(m_q[0]))
                    $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", i, bus.inst_pc, bus.inst_data, m_q[0], rom(m_q[0])); else passes++;
            end
            model_clock();
            @(posedge clk); #1;
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_boot();
        test_backpressure();
        test_redirect();
        test_stall();
        test_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end. It is the xbus master that sits directly upstream of the boot ROM / instruction memory slave.
- Generates sequential word fetches from a PC register and drives the xbus request to the memory slave.
- Captures the returned instruction words into a small FIFO, which the decode stage drains through a valid/ready handshake.
- Supports pipeline redirects (branch/jump/trap), which flush the queue and restart fetch.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- DEPTH, 4, FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_en  in  1  allow fetching; low parks the unit in IDLE.
- redirect_valid  in  1  redirect request from execute/trap logic.
- redirect_pc  in  32  new fetch address.
- xbus_cs  out  1  request strobe to memory slave.
- xbus_we  out  1  constant 0 (read-only master).
- xbus_be  out  4  constant 4'hF.
- xbus_addr  out  32  fetch address; always word aligned.
- xbus_wdata  out  32  constant 0.
- xbus_rdata  in  32  read data, valid in the same cycle as xbus_cs.
- xbus_ready  in  1  slave accepts and returns data this cycle; tie to 1 for ROM.
- inst_valid  out  1  queue head valid.
- inst_data  out  32  queue head instruction.
- inst_pc  out  32  address of queue head.
- inst_ready  in  1  decode accepts head.

Behaviour:
- Reset (async, rst=1):
  - fetch_pc=RESET_PC, count=0, rd/wr pointers=0, state=IDLE.
  - xbus_cs=0, inst_valid=0, inst_data=0, inst_pc=0.
- FSM states: IDLE, FETCH, HOLD.
  - IDLE: xbus_cs=0. Go to FETCH when fetch_en=1.
  - FETCH: xbus_cs=1, xbus_addr=fetch_pc.
    - If xbus_ready=1: push {fetch_pc, xbus_rdata} and set fetch_pc+=4. fetch_pc wraps modulo 2^32, so 32'hFFFF_FFFC is followed by 0.
    - Go to HOLD if the post-cycle count equals DEPTH.
    - Go to IDLE if fetch_en=0.
  - HOLD: xbus_cs=0. Go to FETCH once count<DEPTH after a pop; go to IDLE if fetch_en=0.
- xbus_cs is a registered-state decode only. It has no combinational path from inst_ready or redirect_valid, except as stated under redirect below.
- A push happens only when xbus_cs & xbus_ready. xbus_ready=0 holds the request: same address, no push.
- Pop happens when inst_valid & inst_ready. inst_valid = (count!=0). inst_data and inst_pc come from the head entry via a registered-pointer read.
- Simultaneous push and pop: count unchanged, both pointers advance. Occupancy never exceeds DEPTH, because no request is issued when count==DEPTH.
- Redirect (redirect_valid=1), highest priority:
  - xbus_cs is forced to 0 that cycle (combinational gating allowed), so no push occurs.
  - Any pop that cycle is discarded; decode must ignore inst_valid while redirecting.
  - Next cycle: count=0, pointers reset, fetch_pc = {redirect_pc[31:2],2'b00}.
  - State becomes FETCH if fetch_en=1, else IDLE.
- Redirect while in HOLD or IDLE: same flush, with fetch_pc updated.
- fetch_en dropping mid-stream: current-cycle push still completes, queued entries remain poppable, and no new requests are issued.
- Reset mid-operation: immediate flush to reset values; no partial entry survives.
- Latency: first instruction at RESET_PC appears on inst_valid 2 cycles after rst deassertion with fetch_en=1 (cycle 1 FETCH/push, cycle 2 head valid). Sustained throughput is 1 instr/cycle with xbus_ready=1 and inst_ready=1.

Test Plan:
- Boot: rst pulse, fetch_en=1, xbus_ready=1, inst_ready=1, ROM returns 32'h00000093 at 0x0 and 32'h00000113 at 0x4 -> inst_pc 0x0, 0x4, 0x8… on consecutive cycles with matching inst_data; xbus_we=0, xbus_be=4'hF throughout.
- Backpressure: inst_ready=0 -> exactly DEPTH=4 pushes (addr 0x0–0xC), then xbus_cs=0 in HOLD. Raise inst_ready -> pops 0x0,0x4,0x8,0xC in order, then fetch resumes at 0x10 with no skipped or duplicated PCs.
- Redirect: during streaming, assert redirect_valid with redirect_pc=32'h0000_0083 -> no push that cycle; next cycle count=0; next fetch address 0x80; first new inst_pc=0x80.
- Slave stall: xbus_ready=0 for 3 cycles at addr 0x8 -> xbus_addr stays 0x8, no push; on ready, entry 0x8 is pushed once.
- Wrap: redirect to 32'hFFFF_FFFC -> following fetch address 0x0000_0000.
- Async reset mid-stream with queue holding 3 entries -> inst_valid=0 and xbus_cs=0 immediately, without waiting for a clock edge; fetch restarts at RESET_PC.
